mem_port_arbiter: RTL

Sequencing arbiter that shares the single-ported unified data/instruction memory between the fetch stage and the memory stage. It grants one requester at a time and holds the memory's enable, write, address and write-data inputs stable for a parameterised access latency. It returns read data and a one-cycle completion pulse to the granted requester, and drives stall to each waiting requester. It sits between the fetch/memory pipeline stages and the memory instance.

---
 rtl/mem_port_arbiter.sv | 116 +++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch and data stages: grants one
// requester at a time, holds the access for LATENCY cycles, returns data with a done pulse.
module mem_port_arbiter #(
  parameter int LATENCY = 2,
  parameter int AW      = 16,
  parameter int DW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_done,
  output logic          if_stall,
  input  logic          dm_req,
  input  logic          dm_wr,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_done,
  output logic          dm_stall,
  output logic          mem_enable,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          err
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } acc_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

  state_t        r_state, w_state_nxt;
  acc_t          r_acc, w_acc_nxt;
  logic          r_owner;
  logic          r_last_grant;
  logic [3:0]    r_cnt;
  logic [DW-1:0] r_if_rdata, r_dm_rdata;

  logic w_if_elig, w_dm_elig;
  logic w_grant, w_grant_dm;

  always_comb begin
    w_if_elig   = if_req;
    w_dm_elig   = dm_req;
    w_grant     = 1'b0;
    w_grant_dm  = 1'b0;
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    // The port completing this cycle may still hold req high; don't re-grant it.
    if (r_state == S_DONE) begin
      if (r_owner == OWN_DM) w_dm_elig = 1'b0;
      else                   w_if_elig = 1'b0;
    end
    case (r_state)
      S_ACCESS: if (r_cnt == 4'd0) w_state_nxt = S_DONE;
      default: begin
        w_grant     = w_if_elig | w_dm_elig;
        w_grant_dm  = w_dm_elig & (~w_if_elig | (r_last_grant == OWN_IF));
        w_state_nxt = w_grant ? S_ACCESS : S_IDLE;
        if (w_grant_dm) w_acc_nxt = '{wr: dm_wr, addr: dm_addr, wdata: dm_wdata};
        else            w_acc_nxt = '{wr: 1'b0,  addr: if_addr, wdata: '0};
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_acc        <= '0;
      r_owner      <= OWN_IF;
      // Treated as if fetch was served last, so data wins the first contention.
      r_last_grant <= OWN_IF;
      r_cnt        <= 4'd0;
      r_if_rdata   <= '0;
      r_dm_rdata   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_acc        <= w_acc_nxt;
        r_owner      <= w_grant_dm;
        r_last_grant <= w_grant_dm;
        r_cnt        <= 4'(LATENCY - 1);
      end else if (r_state == S_ACCESS) begin
        if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
        if (r_cnt == 4'd0 && !r_acc.wr) begin
          if (r_owner == OWN_DM) r_dm_rdata <= mem_rdata;
          else                   r_if_rdata <= mem_rdata;
        end
      end
    end
  end

  assign mem_enable = (r_state == S_ACCESS);
  assign mem_wr     = (r_state == S_ACCESS) & r_acc.wr;
  assign mem_addr   = r_acc.addr;
  assign mem_wdata  = r_acc.wdata;

  assign if_done  = (r_state == S_DONE) & (r_owner == OWN_IF);
  assign dm_done  = (r_state == S_DONE) & (r_owner == OWN_DM);
  assign err      = (r_state == S_DONE) & r_acc.addr[0];
  assign if_rdata = r_if_rdata;
  assign dm_rdata = r_dm_rdata;

  assign if_stall = if_req & ~if_done;
  assign dm_stall = dm_req & ~dm_done;

endmodule
